// File: rtl/router_pkg.sv
// Shared router definitions: packet FSM states, sizing and header packing.
// Used by both the transmit framer and the router receive side.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } state_e;

  localparam logic [3:0] MAX_LEN = 4'd15;
  localparam logic [1:0] NUM_CH  = 2'd3;

  localparam int HDR_PAD_W  = 2;
  localparam int HDR_LEN_W  = 4;
  localparam int HDR_DEST_W = 2;

  function automatic logic [7:0] hdr_pack(
    input logic [HDR_LEN_W-1:0]  len,
    input logic [HDR_DEST_W-1:0] dest
  );
    return {{HDR_PAD_W{1'b0}}, len, dest};
  endfunction

endpackage

// File: rtl/router_pkt_tx.sv
// Packet framer: header, payload, XOR parity, one idle gap.
// Output byte is registered; busy stalls the byte in place.
module router_pkt_tx
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_dest,
  input  logic [3:0] cmd_len,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       busy,
  output logic       done,
  output logic       err
);

  state_e     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       vld_q, vld_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] par_q, par_d;
  logic       err_q, err_d;
  logic       fetch;
  logic [7:0] hdr;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    vld_d     = vld_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    err_d     = 1'b0;
    cmd_ready = 1'b0;
    pl_ready  = 1'b0;
    done      = 1'b0;
    fetch     = 1'b0;
    hdr       = hdr_pack(cmd_len, cmd_dest);

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = rst_n;
        data_d    = 8'h00;
        vld_d     = 1'b0;
        if (cmd_valid) begin
          if (cmd_dest < NUM_CH) begin
            state_d = ST_HDR;
            data_d  = hdr;
            vld_d   = 1'b1;
            par_d   = hdr;
            cnt_d   = cmd_len;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (!busy) begin
          if (cnt_q == 4'd0) begin
            state_d = ST_PAR;
            data_d  = par_q;
          end else begin
            // first payload byte is fetched as the header leaves
            state_d = ST_DATA;
            fetch   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (!vld_q || !busy) begin
          if (cnt_q == 4'd0) begin
            state_d = ST_PAR;
            data_d  = par_q;
            vld_d   = 1'b1;
          end else begin
            fetch = 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (!busy) begin
          done    = 1'b1;
          state_d = ST_GAP;
          data_d  = 8'h00;
          vld_d   = 1'b0;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        data_d  = 8'h00;
        vld_d   = 1'b0;
      end
    endcase

    // a missing payload byte leaves a bubble; the count stays put
    if (fetch) begin
      pl_ready = 1'b1;
      if (pl_valid) begin
        data_d = pl_data;
        vld_d  = 1'b1;
        cnt_d  = cnt_q - 4'd1;
        par_d  = par_q ^ pl_data;
      end else begin
        data_d = 8'h00;
        vld_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
      cnt_q   <= 4'd0;
      par_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

  assign pkt_data  = data_q;
  assign pkt_valid = vld_q;
  assign err       = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed vector table, corner sequences,
// and random traffic against a packet-level stream scoreboard.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_dest = 2'd0;
  logic [3:0] cmd_len = 4'd0;
  logic       pl_valid = 1'b0;
  logic       pl_ready;
  logic [7:0] pl_data = 8'h00;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       busy = 1'b0;
  logic       done;
  logic       err;

  router_pkt_tx dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dest(cmd_dest), .cmd_len(cmd_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  dest;
    logic [3:0]  len;
    logic [31:0] pl;
    logic [47:0] exp;
    int          n;
    bit          is_err;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [7:0] pl_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  bit         got_d[$];
  logic [7:0] exp_q[$];
  bit         exp_last[$];

  bit   rand_mode = 1'b0;
  bit   acc = 1'b0;
  int   stall_left = 0;
  logic [7:0] stall_byte = 8'h00;
  int   gap_left = 0;
  int   gap_at = 0;

  bit         prev_stall = 1'b0;
  bit         prev_done = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         err_exp = 1'b0;
  bit         xfer;
  bit         hold_pl;

  vec_t vecs[5];

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // input driver: busy, payload stream
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) begin
      busy = ($urandom_range(0, 3) == 0);
    end else if (stall_left > 0 && pkt_valid && pkt_data == stall_byte) begin
      busy = 1'b1;
      stall_left--;
    end else begin
      busy = 1'b0;
    end
    hold_pl = (gap_left > 0 && pl_q.size() == gap_at);
    if (hold_pl) gap_left--;
    pl_valid = (pl_q.size() > 0) && !hold_pl &&
               (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    pl_data = (pl_q.size() > 0) ? pl_q[0] : 8'h00;
  end

  // monitor and scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      err_exp    = 1'b0;
    end else begin
      chk(pkt_valid || pkt_data == 8'h00, "idle_data",
          32'(pkt_data), 32'h0);
      chk(err == err_exp, "err", 32'(err), 32'(err_exp));
      if (prev_stall)
        chk(pkt_valid && pkt_data == prev_data, "hold",
            32'(pkt_data), 32'(prev_data));
      if (prev_done)
        chk(!pkt_valid, "gap", 32'(pkt_valid), 32'h0);
      if (pl_ready)
        chk(pl_q.size() > 0, "pl_extra", 32'(pl_q.size()), 32'h1);
      xfer = pkt_valid && !busy;
      if (xfer) begin
        got_q.push_back(pkt_data);
        got_t.push_back(cyc);
        got_d.push_back(done);
        if (rand_mode) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "extra_byte", 32'(pkt_data), 32'h0);
          end else begin
            chk(pkt_data == exp_q[0], "rand_byte",
                32'(pkt_data), 32'(exp_q[0]));
            chk(done == exp_last[0], "rand_done",
                32'(done), 32'(exp_last[0]));
            void'(exp_q.pop_front());
            void'(exp_last.pop_front());
          end
        end
      end else begin
        chk(!done, "done_spur", 32'(done), 32'h0);
      end
      if (done) done_cnt++;
      err_exp = cmd_valid && cmd_ready && cmd_dest == 2'd3;
      if (pl_valid && pl_ready) void'(pl_q.pop_front());
      if (cmd_valid && cmd_ready) begin
        acc = 1'b1;
        if (rand_mode && cmd_dest != 2'd3) begin
          logic [7:0] p, b;
          p = {2'b00, cmd_len, cmd_dest};
          exp_q.push_back(p);
          exp_last.push_back(1'b0);
          for (int i = 0; i < int'(cmd_len); i++) begin
            b = 8'($urandom);
            pl_q.push_back(b);
            exp_q.push_back(b);
            exp_last.push_back(1'b0);
            p = p ^ b;
          end
          exp_q.push_back(p);
          exp_last.push_back(1'b1);
        end
      end
      prev_stall = pkt_valid && busy;
      prev_data  = pkt_data;
      prev_done  = done;
    end
  end

  task automatic wait_done(input int budget);
    int s;
    int i;
    s = done_cnt;
    i = 0;
    while (done_cnt == s && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk(done_cnt == s + 1, "done_timeout", 32'(done_cnt), 32'(s + 1));
  endtask

  task automatic run_vec(input vec_t v, input bit tight);
    int a;
    got_q.delete();
    got_t.delete();
    got_d.delete();
    for (int i = 0; i < int'(v.len); i++) pl_q.push_back(v.pl[8*i +: 8]);
    @(posedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_dest  = v.dest;
    cmd_len   = v.len;
    @(negedge clk);
    chk(cmd_ready == 1'b1, "cmd_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    a = cyc;
    if (v.is_err) begin
      @(negedge clk);
      chk(err == 1'b1, "err_pulse", 32'(err), 32'h1);
      chk(cmd_ready == 1'b1, "err_ready", 32'(cmd_ready), 32'h1);
      repeat (3) begin
        chk(!pkt_valid && !pl_ready, "err_quiet",
            32'({pkt_valid, pl_ready}), 32'h0);
        @(negedge clk);
      end
      chk(pl_q.size() == int'(v.len), "err_no_consume",
          32'(pl_q.size()), 32'(v.len));
      pl_q.delete();
    end else begin
      wait_done(200);
      @(posedge clk);
      chk(got_q.size() == v.n, "pkt_len", 32'(got_q.size()), 32'(v.n));
      for (int i = 0; i < v.n && i < got_q.size(); i++) begin
        chk(got_q[i] == v.exp[8*i +: 8], "pkt_byte",
            32'(got_q[i]), 32'(v.exp[8*i +: 8]));
        chk(got_d[i] == (i == v.n - 1), "pkt_done",
            32'(got_d[i]), 32'(i == v.n - 1));
        if (tight)
          chk(got_t[i] == a + i, "pkt_timing",
              32'(got_t[i]), 32'(a + i));
      end
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    vecs[0] = '{dest: 2'd0, len: 4'd2, pl: 32'h0000_1110,
                exp: 48'h0000_0911_1008, n: 4, is_err: 1'b0};
    vecs[1] = '{dest: 2'd2, len: 4'd1, pl: 32'h0000_0020,
                exp: 48'h0000_0026_2006, n: 3, is_err: 1'b0};
    vecs[2] = '{dest: 2'd1, len: 4'd0, pl: 32'h0,
                exp: 48'h0000_0000_0101, n: 2, is_err: 1'b0};
    vecs[3] = '{dest: 2'd3, len: 4'd4, pl: 32'h0403_0201,
                exp: 48'h0, n: 0, is_err: 1'b1};
    vecs[4] = '{dest: 2'd2, len: 4'd3, pl: 32'h00ff_5aa5,
                exp: 48'h000e_ff5a_a50e, n: 5, is_err: 1'b0};

    #3;
    chk({pkt_valid, cmd_ready, pl_ready, done, err} == 5'b0, "reset_ctl",
        32'({pkt_valid, cmd_ready, pl_ready, done, err}), 32'h0);
    chk(pkt_data == 8'h00, "reset_data", 32'(pkt_data), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk(cmd_ready == 1'b1, "ready_after_rst", 32'(cmd_ready), 32'h1);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], 1'b1);

    // busy held three cycles on the second payload byte
    stall_byte = 8'h32;
    stall_left = 3;
    run_vec('{dest: 2'd0, len: 4'd3, pl: 32'h0033_3231,
              exp: 48'h0000_3c33_3231 << 8 | 48'h0c, n: 5, is_err: 1'b0},
            1'b0);
    chk(got_t.size() == 5 && got_t[2] == got_t[1] + 4, "stall_timing",
        32'(got_t.size() > 2 ? got_t[2] - got_t[1] : -1), 32'h4);

    // payload withheld two cycles mid-packet
    gap_at   = 2;
    gap_left = 2;
    run_vec('{dest: 2'd1, len: 4'd4, pl: 32'h4443_4241,
              exp: 48'h1544_4342_4111, n: 6, is_err: 1'b0}, 1'b0);
    chk(got_t.size() == 6 && got_t[3] == got_t[2] + 3, "bubble_timing",
        32'(got_t.size() > 3 ? got_t[3] - got_t[2] : -1), 32'h3);

    // reset in the middle of the payload
    got_q.delete();
    for (int i = 0; i < 4; i++) pl_q.push_back(8'(8'h51 + i));
    @(posedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_dest  = 2'd0;
    cmd_len   = 4'd4;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && got_q.size() < 2; i++) @(posedge clk);
    chk(got_q.size() >= 2, "rst_setup", 32'(got_q.size()), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk({pkt_valid, cmd_ready, pl_ready, done, err} == 5'b0, "rst_mid_ctl",
        32'({pkt_valid, cmd_ready, pl_ready, done, err}), 32'h0);
    chk(pkt_data == 8'h00, "rst_mid_data", 32'(pkt_data), 32'h0);
    pl_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk(cmd_ready && !pkt_valid, "rst_mid_ready",
        32'({cmd_ready, pkt_valid}), 32'h2);
    run_vec(vecs[0], 1'b1);

    // random traffic against the stream scoreboard
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      if (cmd_valid && acc) cmd_valid = 1'b0;
      acc = 1'b0;
      if (!cmd_valid && $urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b1;
        cmd_dest  = 2'($urandom);
        cmd_len   = 4'($urandom);
      end
    end
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #2;
      if (cmd_valid && acc) cmd_valid = 1'b0;
      acc = 1'b0;
      if (!cmd_valid && exp_q.size() == 0 && pl_q.size() == 0) break;
    end
    chk(exp_q.size() == 0 && !cmd_valid, "rand_drain",
        32'(exp_q.size()), 32'h0);
    repeat (4) @(posedge clk);
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
